// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } div_state_t;

    // Iteration counter width: must hold 0 .. width-1 with headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational a - b as a + ~b + 1 using a rippled generate/propagate carry chain.
module cla_subtractor #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    always_comb begin
        b_inv    = ~b;
        gen      = a & b_inv;
        prop     = a ^ b_inv;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        diff   = prop ^ carry[WIDTH-1:0];
        borrow = ~carry[WIDTH];
    end

endmodule

// File: rtl/param_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake,
// results held in output registers until the next operation completes.
module param_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // The working quotient register starts as the dividend, so shifting {rem, quo}
    // feeds dividend bits into rem MSB first while quotient bits fill quo from the LSB.
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    cla_subtractor #(.WIDTH(WIDTH + 1)) u_trial_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign accept    = (state_q == IDLE) && start;
    assign last_iter = (cnt_q == LAST_CNT);
    assign rem_step  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (divisor == '0) ? FINISH : RUN;
            RUN:     if (last_iter) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FINISH);
    end

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (accept) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            dbz_d = 1'b0;
            if (divisor == '0) begin
                quotient_d  = '1;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end
        end else if (state_q == RUN) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CNT_W'(1);
            // Publish on the final iteration so results are valid while done is high.
            if (last_iter) begin
                quotient_d  = quo_step;
                remainder_d = rem_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_param_divider.sv
// Scoreboard bench for param_divider at WIDTH = 8.
module tb_param_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           s_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    param_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("latency", cyc - e.s_cyc, e.lat);
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int s);
        exp_t e;
        e.s_cyc = s;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = W'(int'(a) / int'(b));
            e.r   = W'(int'(a) % int'(b));
            e.dbz = 1'b0;
            e.lat = W + 1;
        end
        return e;
    endfunction

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom_range(0, 255);
        divisor  = $urandom_range(0, 255);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 40, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        drive_start(a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 with cycle-exact busy/done, plus a start during FINISH that must be ignored
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        sb.push_back(model(8'd100, 8'd7, cyc));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            chk("t1_busy", busy, (c <= 9));
            chk("t1_done", done, (c == 9));
            if (c == 9) begin
                start    = 1'b1;
                dividend = 8'd1;
                divisor  = 8'd1;
            end
            if (c == 10) start = 1'b0;
        end
        chk("finish_start_ignored", busy, 1'b0);

        run_op(8'd255, 8'd1);
        run_op(8'd5, 8'd9);
        run_op(8'd255, 8'd255);

        run_op(8'd37, 8'd0);
        chk("dbz_held", div_by_zero, 1'b1);
        run_op(8'd20, 8'd4);
        chk("dbz_cleared", div_by_zero, 1'b0);

        // 200 / 3 with a 9 / 9 start at cycle 4 that must be ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        sb.push_back(model(8'd200, 8'd3, cyc));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd9;
            end
        end
        start = 1'b0;
        wait_idle();

        // Reset at cycle 5 of 100 / 7: result must be lost with no done pulse
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_done", done, 1'b0);
        chk("midrun_rst_quotient", quotient, 0);
        chk("midrun_rst_remainder", remainder, 0);
        chk("midrun_rst_dbz", div_by_zero, 1'b0);
        repeat (12) @(negedge clk);
        run_op(8'd50, 8'd5);

        // Reset wins over a simultaneous start
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_over_start_busy", busy, 1'b0);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            run_op(a, b);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
